// File: rtl/sched_1553_pkg.sv
// Shared types and constants for the 1553 bus-controller message scheduler.
// Table entry layout: {csw_flag, dw_flag, word[15:0]}.
package sched_1553_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_STROBE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_WAIT_RESP,
    S_GAP,
    S_DONE
  } state_t;

  localparam int CSW_BIT = 17;
  localparam int DW_BIT  = 16;
  localparam logic [1:0] FLG_END = 2'b00;
  localparam int TMR_W = 16;

  function automatic logic is_end(input logic [17:0] entry);
    return entry[CSW_BIT:DW_BIT] == FLG_END;
  endfunction

endpackage

// File: rtl/sched_timer.sv
// Loadable down-counter with terminal-count flag; parks at zero.
module sched_timer
  import sched_1553_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cnt <= '0;
    else if (load)       cnt <= load_val;
    else if (cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/msg_sched_1553.sv
// 1553 BC message scheduler: walks the message table, strobes words into the
// encoder, waits for RT status with retry. Optional MSG_SCHED_BUS_SWITCH_EN flips bus on retry.
module msg_sched_1553
  import sched_1553_pkg::*;
#(
  parameter int ADDR_W       = 7,
  parameter int RESP_TIMEOUT = 112,
  parameter int GAP_CYCLES   = 32,
  parameter int BUSY_WAIT    = 16,
  parameter int MAX_RETRY    = 1
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [17:0]       rd_data,
  output logic [15:0]       tx_dword,
  output logic              tx_csw,
  output logic              tx_dw,
  input  logic              tx_busy,
  input  logic              rx_dval,
  input  logic              rx_csw,
  input  logic [15:0]       rx_dword,
  input  logic              rx_perr,
  output logic              bus_sel,
  output logic              busy,
  output logic              done,
  output logic              err_timeout,
  output logic              err_enc,
  output logic [7:0]        msg_count,
  output logic [15:0]       status_word
);

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   addr, msg_start;
  logic                in_msg, wrap_pend, word_csw;
  logic [3:0]          retry_cnt;

  logic                tmr_load, tmr_tc;
  logic [TMR_W-1:0]    tmr_val;

  logic ev_start, ev_load_word, ev_msg_begin, ev_addr_inc, ev_wrap;
  logic ev_resp_ok, ev_retry, ev_exhaust, ev_enc_err;

  logic csw_f, entry_end, resp_ok, retry_left;

  assign csw_f      = rd_data[CSW_BIT];
  assign entry_end  = is_end(rd_data);
  assign resp_ok    = rx_dval & rx_csw & ~rx_perr;
  assign retry_left = retry_cnt < 4'(MAX_RETRY);

  sched_timer #(.W(TMR_W)) u_tmr (
    .clk      (sys_clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Each timed state lasts exactly N cycles: the timer is loaded with N-1 on entry.
  always_comb begin
    state_nx     = state;
    tmr_load     = 1'b0;
    tmr_val      = '0;
    ev_start     = 1'b0;
    ev_load_word = 1'b0;
    ev_msg_begin = 1'b0;
    ev_addr_inc  = 1'b0;
    ev_wrap      = 1'b0;
    ev_resp_ok   = 1'b0;
    ev_retry     = 1'b0;
    ev_exhaust   = 1'b0;
    ev_enc_err   = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        ev_start = 1'b1;
        state_nx = S_FETCH;
      end
      S_FETCH: state_nx = abort ? S_DONE : S_LOAD;
      S_LOAD: begin
        // A command or end marker after words already sent closes the message.
        if ((csw_f || entry_end) && in_msg) begin
          state_nx = S_WAIT_RESP;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(RESP_TIMEOUT - 1);
        end else if (entry_end) begin
          state_nx = S_DONE;
        end else begin
          ev_load_word = 1'b1;
          ev_msg_begin = csw_f;
          state_nx     = S_STROBE;
        end
      end
      S_STROBE: begin
        state_nx = S_WAIT_BUSY;
        tmr_load = 1'b1;
        tmr_val  = TMR_W'(BUSY_WAIT - 1);
      end
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          state_nx = S_WAIT_DONE;
        end else if (tmr_tc) begin
          ev_enc_err = 1'b1;
          state_nx   = S_DONE;
        end
      end
      S_WAIT_DONE: if (!tx_busy) begin
        if (&addr) begin
          ev_wrap  = 1'b1;
          state_nx = S_WAIT_RESP;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(RESP_TIMEOUT - 1);
        end else begin
          ev_addr_inc = 1'b1;
          state_nx    = S_FETCH;
        end
      end
      S_WAIT_RESP: begin
        // Response wins over a timeout landing on the same cycle.
        if (resp_ok || (tmr_tc && !retry_left)) begin
          ev_resp_ok = resp_ok;
          ev_exhaust = ~resp_ok;
          state_nx   = wrap_pend ? S_DONE : S_GAP;
          tmr_load   = 1'b1;
          tmr_val    = TMR_W'(GAP_CYCLES - 1);
        end else if (tmr_tc) begin
          ev_retry = 1'b1;
          state_nx = S_GAP;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(GAP_CYCLES - 1);
        end
      end
      S_GAP: begin
        if (abort)       state_nx = S_DONE;
        else if (tmr_tc) state_nx = S_FETCH;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      addr        <= '0;
      msg_start   <= '0;
      in_msg      <= 1'b0;
      wrap_pend   <= 1'b0;
      word_csw    <= 1'b0;
      retry_cnt   <= '0;
      tx_dword    <= '0;
      err_timeout <= 1'b0;
      err_enc     <= 1'b0;
      msg_count   <= '0;
      status_word <= '0;
    end else begin
      if (ev_start) begin
        addr        <= base_addr;
        msg_start   <= base_addr;
        in_msg      <= 1'b0;
        wrap_pend   <= 1'b0;
        retry_cnt   <= '0;
        err_timeout <= 1'b0;
        err_enc     <= 1'b0;
        msg_count   <= '0;
      end
      if (ev_load_word) begin
        tx_dword <= rd_data[15:0];
        word_csw <= csw_f;
        in_msg   <= 1'b1;
      end
      if (ev_msg_begin) msg_start <= addr;
      if (ev_addr_inc)  addr <= addr + 1'b1;
      if (ev_wrap)      wrap_pend <= 1'b1;
      if (ev_enc_err)   err_enc <= 1'b1;
      if (ev_resp_ok) begin
        status_word <= rx_dword;
        retry_cnt   <= '0;
        in_msg      <= 1'b0;
        if (msg_count != 8'hFF) msg_count <= msg_count + 8'd1;
      end
      // Retry re-walks the message from its command word.
      if (ev_retry) begin
        retry_cnt <= retry_cnt + 4'd1;
        addr      <= msg_start;
        in_msg    <= 1'b0;
        wrap_pend <= 1'b0;
      end
      if (ev_exhaust) begin
        err_timeout <= 1'b1;
        retry_cnt   <= '0;
        in_msg      <= 1'b0;
      end
    end
  end

`ifdef MSG_SCHED_BUS_SWITCH_EN
  logic bus_q;
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n)                     bus_q <= 1'b0;
    else if (ev_start || ev_resp_ok) bus_q <= 1'b0;
    else if (ev_retry)              bus_q <= ~bus_q;
  end
  assign bus_sel = bus_q;
`else
  assign bus_sel = 1'b0;
`endif

  assign rd_en   = (state == S_FETCH) & ~abort;
  assign rd_addr = addr;
  assign tx_csw  = (state == S_STROBE) &  word_csw;
  assign tx_dw   = (state == S_STROBE) & ~word_csw;
  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);

endmodule

// File: tb/tb_msg_sched_1553.sv
// Directed bench for msg_sched_1553: table memory, encoder and RT responder models.
module tb_msg_sched_1553;

  localparam int AW = 7;
`ifdef MSG_SCHED_BUS_SWITCH_EN
  localparam logic EXP_BUS2 = 1'b1;
`else
  localparam logic EXP_BUS2 = 1'b0;
`endif

  logic          sys_clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0, abort = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [17:0]   rd_data = '0;
  logic [15:0]   tx_dword;
  logic          tx_csw, tx_dw, tx_busy;
  logic          rx_dval = 1'b0, rx_csw = 1'b0, rx_perr = 1'b0;
  logic [15:0]   rx_dword = '0;
  logic          bus_sel, busy, done, err_timeout, err_enc;
  logic [7:0]    msg_count;
  logic [15:0]   status_word;

  always #5 sys_clk = ~sys_clk;

  msg_sched_1553 dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .start(start), .abort(abort),
    .base_addr(base_addr), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .tx_dword(tx_dword), .tx_csw(tx_csw), .tx_dw(tx_dw), .tx_busy(tx_busy),
    .rx_dval(rx_dval), .rx_csw(rx_csw), .rx_dword(rx_dword), .rx_perr(rx_perr),
    .bus_sel(bus_sel), .busy(busy), .done(done), .err_timeout(err_timeout),
    .err_enc(err_enc), .msg_count(msg_count), .status_word(status_word)
  );

  logic [17:0] mem [128];
  int          checks = 0, errors = 0;
  int          n_csw, n_dw, n_done, n_rd0;
  logic [15:0] words[$];
  logic        bus_q[$];
  logic        enc_dead = 1'b0;
  int          enc_cnt = 0;

  // Table memory: one-cycle read latency.
  always @(posedge sys_clk) if (rd_en) rd_data <= mem[rd_addr];

  // Encoder: busy from 2 cycles after a strobe for 20 cycles.
  always @(posedge sys_clk) begin
    if (enc_cnt > 0) enc_cnt <= enc_cnt - 1;
    if ((tx_csw || tx_dw) && !enc_dead) enc_cnt <= 22;
  end
  assign tx_busy = (enc_cnt != 0) && (enc_cnt <= 20);

  always @(negedge sys_clk) begin
    if (tx_csw) begin n_csw++; words.push_back(tx_dword); bus_q.push_back(bus_sel); end
    if (tx_dw)  begin n_dw++;  words.push_back(tx_dword); end
    if (rd_en && rd_addr == 7'd0) n_rd0++;
    if (done) n_done++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge sys_clk); #1;
  endtask

  task automatic clear_mon();
    n_csw = 0; n_dw = 0; n_done = 0; n_rd0 = 0;
    words.delete(); bus_q.delete();
  endtask

  task automatic do_start(input logic [AW-1:0] b);
    base_addr = b; start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic wait_strobes(input int n, input int budget, input string tag);
    int i = 0;
    while ((n_csw + n_dw) < n && i < budget) begin step(); i++; end
    check(tag, 32'((n_csw + n_dw) >= n), 1);
  endtask

  task automatic wait_done(input int budget, input string tag);
    int i = 0;
    while (n_done < 1 && i < budget) begin step(); i++; end
    check(tag, 32'(n_done >= 1), 1);
  endtask

  task automatic send_resp(input logic [15:0] w, input logic perr);
    rx_dval = 1'b1; rx_csw = 1'b1; rx_dword = w; rx_perr = perr;
    step();
    rx_dval = 1'b0; rx_csw = 1'b0; rx_perr = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = '0;
    clear_mon();
    #2 rst_n = 1'b0;
    repeat (3) step();
    check("rst_busy_done", {30'd0, busy, done}, 0);
    check("rst_rd", {24'd0, rd_en, rd_addr}, 0);
    check("rst_tx", {14'd0, tx_csw, tx_dw, tx_dword}, 0);
    check("rst_flags", {29'd0, bus_sel, err_timeout, err_enc}, 0);
    check("rst_count_status", {8'd0, msg_count, status_word}, 0);
    rst_n = 1'b1;
    step();

    // Single message with response
    mem[0] = 18'h20821; mem[1] = 18'h11234; mem[2] = 18'h15678; mem[3] = 18'h00000;
    clear_mon();
    do_start(7'd0);
    wait_strobes(1, 50, "t1_first_strobe");
    do_start(7'h10);
    check("t1_busy", busy, 1);
    wait_strobes(3, 200, "t1_all_strobes");
    repeat (40) step();
    send_resp(16'h0800, 1'b0);
    wait_done(300, "t1_done_seen");
    repeat (5) step();
    check("t1_n_csw", n_csw, 1);
    check("t1_n_dw", n_dw, 2);
    if (words.size() >= 3) begin
      check("t1_w0", words[0], 32'h0821);
      check("t1_w1", words[1], 32'h1234);
      check("t1_w2", words[2], 32'h5678);
    end
    check("t1_msg_count", msg_count, 1);
    check("t1_status", status_word, 32'h0800);
    check("t1_n_done", n_done, 1);
    check("t1_errs", {30'd0, err_timeout, err_enc}, 0);
    check("t1_busy_end", busy, 0);

    // No response: one retry then timeout error
    clear_mon();
    do_start(7'd0);
    wait_done(1500, "t2_done_seen");
    repeat (3) step();
    check("t2_n_csw", n_csw, 2);
    check("t2_n_dw", n_dw, 4);
    check("t2_err_timeout", err_timeout, 1);
    check("t2_msg_count", msg_count, 0);
    check("t2_n_done", n_done, 1);
    check("t2_status_kept", status_word, 32'h0800);
    if (bus_q.size() >= 2) begin
      check("t2_bus_first", bus_q[0], 0);
      check("t2_bus_retry", bus_q[1], 32'(EXP_BUS2));
    end

    // Parity-error word ignored, later valid status accepted
    clear_mon();
    do_start(7'd0);
    check("t3_err_cleared", err_timeout, 0);
    check("t3_bus_cleared", bus_sel, 0);
    wait_strobes(3, 200, "t3_all_strobes");
    repeat (45) step();
    send_resp(16'hDEAD, 1'b1);
    check("t3_perr_ignored", status_word, 32'h0800);
    repeat (38) step();
    send_resp(16'h0801, 1'b0);
    wait_done(300, "t3_done_seen");
    repeat (3) step();
    check("t3_status", status_word, 32'h0801);
    check("t3_msg_count", msg_count, 1);
    check("t3_no_retry", n_csw, 1);
    check("t3_err_timeout", err_timeout, 0);

    // Encoder never goes busy
    clear_mon();
    enc_dead = 1'b1;
    do_start(7'd0);
    wait_strobes(1, 50, "t4_strobe");
    repeat (16) step();
    check("t4_err_enc_early", err_enc, 0);
    step();
    check("t4_err_enc", err_enc, 1);
    check("t4_done", done, 1);
    step();
    check("t4_busy", busy, 0);
    check("t4_words", {n_csw[15:0], n_dw[15:0]}, 32'h0001_0000);
    enc_dead = 1'b0;
    repeat (25) step();

    // Abort during first message's WAIT_DONE
    mem[7'h10] = 18'h21111; mem[7'h11] = 18'h12222; mem[7'h12] = 18'h23333;
    mem[7'h13] = 18'h14444; mem[7'h14] = 18'h00000;
    clear_mon();
    do_start(7'h10);
    wait_strobes(1, 50, "t5_strobe");
    repeat (6) step();
    abort = 1'b1;
    wait_done(100, "t5_done_seen");
    abort = 1'b0;
    repeat (3) step();
    check("t5_n_csw", n_csw, 1);
    check("t5_n_dw", n_dw, 0);
    check("t5_msg_count", msg_count, 0);
    check("t5_addr_advanced", rd_addr, 32'h11);
    check("t5_busy", busy, 0);

    // Address wrap ends the frame after the response
    mem[7'h7E] = 18'h2ABCD; mem[7'h7F] = 18'h10042; mem[0] = 18'h2FFFF;
    clear_mon();
    do_start(7'h7E);
    wait_strobes(2, 100, "t6_strobes");
    repeat (40) step();
    send_resp(16'h0C00, 1'b0);
    wait_done(200, "t6_done_seen");
    repeat (3) step();
    check("t6_no_read_0", n_rd0, 0);
    check("t6_words", {n_csw[15:0], n_dw[15:0]}, 32'h0001_0001);
    if (words.size() >= 2) check("t6_w", {words[0], words[1]}, 32'hABCD_0042);
    check("t6_msg_count", msg_count, 1);
    check("t6_status", status_word, 32'h0C00);
    check("t6_n_done", n_done, 1);

    // Reset mid-frame drops the strobe immediately
    mem[0] = 18'h20821;
    clear_mon();
    do_start(7'd0);
    wait_strobes(1, 50, "t7_strobe");
    rst_n = 1'b0;
    #1;
    check("t7_strobe_dropped", {30'd0, tx_csw, busy}, 0);
    check("t7_regs_reset", {msg_count, status_word}, 0);
    step();
    rst_n = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
